mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit owning HI/LO.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one
// step per clock. Signed operations run on magnitudes and fix the sign
// on the completing edge. Divide-by-zero bypasses the iteration.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] porta,
   input  logic [WIDTH-1:0] portb,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t               r_state;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_dz;
   logic                 r_dzp;     // divide-by-zero pending: finish on next edge
   logic                 r_isdiv;
   logic                 r_sgn;
   logic                 r_sa;
   logic                 r_sb;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_a;       // multiplicand magnitude, or raw dividend on divide-by-zero
   logic [WIDTH-1:0]     r_b;       // divisor magnitude (multiplier lives in r_acc)
   logic [2*WIDTH-1:0]   r_acc;     // {upper, lower}: product, or {remainder, quotient}
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic                 w_sa;
   logic                 w_sb;
   logic                 w_dzreq;
   logic [WIDTH-1:0]     w_amag;
   logic [WIDTH-1:0]     w_bmag;
   logic [WIDTH:0]       w_msum;
   logic [WIDTH:0]       w_rsh;
   logic [WIDTH:0]       w_rdiff;
   logic [2*WIDTH-1:0]   w_step;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_hi;
   logic [WIDTH-1:0]     w_lo;

   // Two's complement negate of a WIDTH-bit value when neg is set.
   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? (~x + WIDTH'(1)) : x;
   endfunction

   // Two's complement negate of a 2*WIDTH-bit value when neg is set.
   function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
      return neg ? (~x + (2*WIDTH)'(1)) : x;
   endfunction

   assign busy = r_busy;
   assign done = r_done;
   assign dz   = r_dz;
   assign hi   = r_hi;
   assign lo   = r_lo;

   // Operand decode at start: signs, magnitudes and divide-by-zero detect.
   always_comb begin
      w_sa    = op[0] & porta[WIDTH-1];
      w_sb    = op[0] & portb[WIDTH-1];
      w_amag  = f_mag(porta, w_sa);
      w_bmag  = f_mag(portb, w_sb);
      w_dzreq = op[1] & (portb == '0);
   end

   // One iteration step and the sign-corrected final HI/LO values.
   always_comb begin
      w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
      w_rsh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_rdiff = w_rsh - {1'b0, r_b};
      if (r_isdiv) begin
         if (!w_rdiff[WIDTH])
            w_step = {w_rdiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         else
            w_step = {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end else begin
         w_step = {w_msum, r_acc[WIDTH-1:1]};
      end

      w_prod = f_neg2(r_acc, r_sgn & (r_sa ^ r_sb));
      if (r_isdiv) begin
         w_lo = f_mag(r_acc[WIDTH-1:0], r_sgn & (r_sa ^ r_sb));
         w_hi = f_mag(r_acc[2*WIDTH-1:WIDTH], r_sgn & r_sa);
      end else begin
         w_lo = w_prod[WIDTH-1:0];
         w_hi = w_prod[2*WIDTH-1:WIDTH];
      end
   end

   // Control FSM with registered outputs, iteration datapath and HI/LO.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
         r_dzp   <= 1'b0;
         r_isdiv <= 1'b0;
         r_sgn   <= 1'b0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_CALC: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_dzp   <= 1'b0;
               end else if (r_dzp) begin
                  r_hi    <= r_a;
                  r_lo    <= '1;
                  r_dz    <= 1'b1;
                  r_done  <= 1'b1;
                  r_dzp   <= 1'b0;
                  r_state <= S_DONE;
               end else if (r_cnt != '0) begin
                  r_acc <= w_step;
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_hi    <= w_hi;
                  r_lo    <= w_lo;
                  r_dz    <= 1'b0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: begin
               if (start && !flush) begin
                  r_isdiv <= op[1];
                  r_sgn   <= op[0];
                  r_sa    <= w_sa;
                  r_sb    <= w_sb;
                  r_a     <= w_dzreq ? porta : w_amag;
                  r_b     <= w_bmag;
                  r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_amag} : {{WIDTH{1'b0}}, w_bmag};
                  r_cnt   <= CW'(WIDTH);
                  r_dzp   <= w_dzreq;
                  r_busy  <= ~w_dzreq;
                  r_state <= S_CALC;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
